search_move_commit: RTL and testbench

- Downstream and feedback stage of StochasticSearch.
- Owns the current-assignment registers that drive StochasticSearch `in_*_current_assigmnets`, and requests one search step at a time through the 8-bit state code.
- When a step's `out_ready` pulse arrives, it picks either the greedy move (best assignment) or a random-walk move (one per-variable candidate) using an LFSR, then commits the choice.
- It loops until the clause checker reports all clauses satisfied, the flip budget is spent, or a watchdog expires.

---
 rtl/search_commit_pkg.sv | 25 ++
 rtl/search_move_commit_if.sv | 37 +++
 rtl/search_lfsr.sv | 27 ++
 rtl/search_move_commit.sv | 146 ++++++++++++++
 tb/tb_search_move_commit.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/search_commit_pkg.sv
// Shared state encoding, LFSR taps and width helpers for the search move/commit stage.
package search_commit_pkg;

   typedef enum logic [2:0] {IDLE, CHECK, REQUEST, WAIT, COMMIT, DONE} state_t;

   // Right-shifting Galois taps for x^16 + x^14 + x^13 + x^11 + 1.
   localparam logic [15:0] LFSR_POLY = 16'hB400;

   function automatic int int_assign_w(input int idx_bits, input int val_bits);
      return (2 ** idx_bits) * val_bits;
   endfunction

   function automatic int bool_assign_w(input int idx_bits);
      return 2 ** idx_bits;
   endfunction

   function automatic int total_vars(input int int_idx_bits, input int bool_idx_bits);
      return (2 ** int_idx_bits) + (2 ** bool_idx_bits);
   endfunction

   function automatic int clog2_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/search_move_commit_if.sv
// Request/result bus between the move/commit stage (master) and StochasticSearch (slave).
interface search_move_commit_if
   import search_commit_pkg::*;
#(
   parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
   parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
   parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE       = 4,
   parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 2,
   parameter int TOTAL_NUMBER_OF_VARIABLES = total_vars(MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
                                                        MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)
);
   localparam int IVW = int_assign_w(MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
                                     MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE);
   localparam int BVW = bool_assign_w(MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX);
   localparam int T   = TOTAL_NUMBER_OF_VARIABLES;

   logic [7:0]                                  search_state;
   logic                                        search_ready;
   logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX:0] bestgain;
   logic [IVW-1:0]                              best_assignment_integer;
   logic [BVW-1:0]                              best_assignment_boolean;
   logic [IVW*T-1:0]                            new_assignments_integer;
   logic [BVW*T-1:0]                            new_assignments_boolean;

   modport master (
      output search_state,
      input  search_ready, bestgain, best_assignment_integer, best_assignment_boolean,
             new_assignments_integer, new_assignments_boolean
   );

   modport slave (
      input  search_state,
      output search_ready, bestgain, best_assignment_integer, best_assignment_boolean,
             new_assignments_integer, new_assignments_boolean
   );

endinterface

// File: rtl/search_lfsr.sv
// Free-running 16-bit Galois LFSR; low bits form the probability sample, top bits the candidate index.
module search_lfsr #(
   parameter logic [15:0] SEED     = 16'hACE1,
   parameter logic [15:0] POLY     = 16'hB400,
   parameter int          SAMPLE_W = 8,
   parameter int          INDEX_W  = 3
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_enable,
   output logic [SAMPLE_W-1:0] o_sample,
   output logic [INDEX_W-1:0]  o_index
);
   logic [15:0] r_value;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_value <= SEED;
      end else if (i_enable) begin
         r_value <= {1'b0, r_value[15:1]} ^ (r_value[0] ? POLY : 16'h0000);
      end
   end

   assign o_sample = r_value[SAMPLE_W-1:0];
   assign o_index  = r_value[15 -: INDEX_W];

endmodule

// File: rtl/search_move_commit.sv
// Feedback stage of StochasticSearch: owns the current assignment, requests steps and commits
// either the greedy or a random-walk move until solved, out of flips, or the watchdog fires.
module search_move_commit
   import search_commit_pkg::*;
#(
   parameter int          MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
   parameter int          MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
   parameter int          MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE       = 4,
   parameter int          MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 2,
   parameter int          TOTAL_NUMBER_OF_VARIABLES = total_vars(MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
                                                                 MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX),
   parameter int          PROB_WIDTH        = 8,
   parameter int          FLIP_WIDTH        = 8,
   parameter int          TIMEOUT_CYCLES    = 64,
   parameter logic [7:0]  SEARCH_STATE_CODE = 8'd2,
   parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
   input  logic                  in_clk,
   input  logic                  in_reset,
   input  logic                  in_start,
   input  logic [int_assign_w(MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
                              MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE)-1:0] in_init_assignment_integer,
   input  logic [bool_assign_w(MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)-1:0] in_init_assignment_boolean,
   input  logic [PROB_WIDTH:0]   in_greedy_threshold,
   input  logic [FLIP_WIDTH-1:0] in_max_flips,
   input  logic                  in_all_satisfied,
   search_move_commit_if.master  bus,
   output logic [int_assign_w(MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
                              MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE)-1:0] out_current_assignment_integer,
   output logic [bool_assign_w(MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)-1:0] out_current_assignment_boolean,
   output logic [FLIP_WIDTH-1:0] out_flip_count,
   output logic                  out_done,
   output logic                  out_solved,
   output logic                  out_timeout
);
   localparam int IVW = int_assign_w(MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
                                     MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE);
   localparam int BVW = bool_assign_w(MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX);
   localparam int T   = TOTAL_NUMBER_OF_VARIABLES;
   localparam int XW  = clog2_w(T) + 1;
   localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [XW-1:0]  T_X     = XW'(T);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

   state_t                                      r_state, w_next;
   logic [IVW-1:0]                              r_cur_int, r_best_int, w_pick_int;
   logic [BVW-1:0]                              r_cur_bool, r_best_bool, w_pick_bool;
   logic [IVW*T-1:0]                            r_new_int;
   logic [BVW*T-1:0]                            r_new_bool;
   logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX:0] r_gain;
   logic [FLIP_WIDTH-1:0]                       r_flips;
   logic                                        r_solved, r_timeout;
   logic [WDW-1:0]                              r_wdog;
   logic [PROB_WIDTH-1:0]                       w_sample;
   logic [XW-1:0]                               w_raw_idx, w_idx;
   logic                                        w_greedy, w_wd_expire;

   search_lfsr #(
      .SEED(LFSR_SEED), .POLY(LFSR_POLY), .SAMPLE_W(PROB_WIDTH), .INDEX_W(XW)
   ) u_lfsr (
      .i_clk(in_clk), .i_rst_n(in_reset), .i_enable(1'b1),
      .o_sample(w_sample), .o_index(w_raw_idx)
   );

   // Index field is one bit wider than needed; one fold brings it into 0..T-1.
   assign w_idx       = (w_raw_idx >= T_X) ? w_raw_idx - T_X : w_raw_idx;
   assign w_greedy    = ({1'b0, w_sample} < in_greedy_threshold) && (r_gain != '0);
   assign w_wd_expire = (r_wdog == WD_LAST);
   assign w_pick_int  = w_greedy ? r_best_int  : r_new_int[int'(w_idx) * IVW +: IVW];
   assign w_pick_bool = w_greedy ? r_best_bool : r_new_bool[int'(w_idx) * BVW +: BVW];

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_start) w_next = CHECK;
         CHECK:   w_next = (in_all_satisfied || (r_flips == in_max_flips)) ? DONE : REQUEST;
         REQUEST: w_next = WAIT;
         WAIT: begin
            if (bus.search_ready)  w_next = COMMIT;
            else if (w_wd_expire)  w_next = DONE;
         end
         COMMIT:  w_next = CHECK;
         DONE:    if (in_start) w_next = CHECK;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         r_state    <= IDLE;
         r_cur_int  <= '0;
         r_cur_bool <= '0;
         r_flips    <= '0;
         r_solved   <= 1'b0;
         r_timeout  <= 1'b0;
         r_wdog     <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE, DONE: begin
               if (in_start) begin
                  r_cur_int  <= in_init_assignment_integer;
                  r_cur_bool <= in_init_assignment_boolean;
                  r_flips    <= '0;
                  r_solved   <= 1'b0;
                  r_timeout  <= 1'b0;
               end
            end
            CHECK:   if (in_all_satisfied) r_solved <= 1'b1;
            REQUEST: r_wdog <= '0;
            WAIT: begin
               if (!bus.search_ready) begin
                  if (w_wd_expire) r_timeout <= 1'b1;
                  else             r_wdog    <= r_wdog + WDW'(1);
               end
            end
            COMMIT: begin
               r_cur_int  <= w_pick_int;
               r_cur_bool <= w_pick_bool;
               if (r_flips != '1) r_flips <= r_flips + FLIP_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

   // Results are held from the ready pulse so bus activity during COMMIT cannot leak in.
   always_ff @(posedge in_clk) begin
      if (r_state == WAIT && bus.search_ready) begin
         r_gain      <= bus.bestgain;
         r_best_int  <= bus.best_assignment_integer;
         r_best_bool <= bus.best_assignment_boolean;
         r_new_int   <= bus.new_assignments_integer;
         r_new_bool  <= bus.new_assignments_boolean;
      end
   end

   assign bus.search_state                = (r_state == REQUEST || r_state == WAIT) ? SEARCH_STATE_CODE : 8'd0;
   assign out_current_assignment_integer = r_cur_int;
   assign out_current_assignment_boolean = r_cur_bool;
   assign out_flip_count                 = r_flips;
   assign out_done                       = (r_state == DONE);
   assign out_solved                     = r_solved;
   assign out_timeout                    = r_timeout;

endmodule

// File: tb/tb_search_move_commit.sv
// Bench for search_move_commit: start-decision vector table, directed multi-cycle corner cases,
// and randomized steps predicted by a reference LFSR and move-selection model.
module tb_search_move_commit;

   typedef struct packed {
      logic [7:0] ii;
      logic [1:0] ib;
      logic       sat;
      logic [7:0] mf;
      logic       exp_done;
      logic       exp_solved;
      logic       exp_req;
   } vec_t;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       start     = 1'b0;
   logic [7:0] init_int  = '0;
   logic [1:0] init_bool = '0;
   logic [8:0] thr       = '0;
   logic [7:0] max_flips = '0;
   logic       sat       = 1'b0;
   logic [7:0] cur_int;
   logic [1:0] cur_bool;
   logic [7:0] flips;
   logic       done, solved, tout;
   logic [15:0] m_lfsr;
   int         n_checks = 0;
   int         n_pass   = 0;
   vec_t       vecs [4];

   search_move_commit_if bus ();

   search_move_commit dut (
      .in_clk(clk), .in_reset(rst_n), .in_start(start),
      .in_init_assignment_integer(init_int), .in_init_assignment_boolean(init_bool),
      .in_greedy_threshold(thr), .in_max_flips(max_flips), .in_all_satisfied(sat),
      .bus(bus),
      .out_current_assignment_integer(cur_int), .out_current_assignment_boolean(cur_bool),
      .out_flip_count(flips), .out_done(done), .out_solved(solved), .out_timeout(tout)
   );

   always #5 clk = ~clk;

   // Reference LFSR: halve the state, fold the shifted-out bit back in through the tap mask.
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v / 16'd2) ^ (((v % 16'd2) != 16'd0) ? 16'hB400 : 16'h0000);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= lfsr_next(m_lfsr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      bus.search_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_start(input logic [7:0] ii, input logic [1:0] ib);
      @(negedge clk);
      init_int  = ii;
      init_bool = ib;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_request(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.search_state != 8'd0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_checks++;
         $display("FAIL wait_request: search_state stayed 0x%0h, expected 0x2 within 40 cycles", bus.search_state);
      end
   endtask

   // One search step: pulse ready in WAIT, note the LFSR seen during COMMIT, return in CHECK.
   task automatic do_step(input bit scramble, output logic [15:0] l);
      bit ok;
      l = 16'h0000;
      wait_request(ok);
      if (ok) begin
         @(negedge clk);
         bus.search_ready = 1'b1;
         @(negedge clk);
         bus.search_ready = 1'b0;
         l = m_lfsr;
         if (scramble) begin
            bus.bestgain                = ~bus.bestgain;
            bus.best_assignment_integer = ~bus.best_assignment_integer;
            bus.best_assignment_boolean = ~bus.best_assignment_boolean;
            bus.new_assignments_integer = ~bus.new_assignments_integer;
            bus.new_assignments_boolean = ~bus.new_assignments_boolean;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation still running, expected to finish");
      $fatal(1, "time limit exceeded");
   end

   initial begin
      logic [15:0] l;
      int          idx;
      bit          ok;
      bit          seq_req;
      bit          seen [4];
      int          n_seen;
      bit          greedy;
      logic [7:0]  e_int, bi;
      logic [1:0]  e_bool, bb;
      logic [31:0] ni;
      logic [7:0]  nb;
      logic [8:0]  th;
      logic [2:0]  g;

      bus.search_ready            = 1'b0;
      bus.bestgain                = '0;
      bus.best_assignment_integer = '0;
      bus.best_assignment_boolean = '0;
      bus.new_assignments_integer = 32'h33221100;
      bus.new_assignments_boolean = 8'hE4;

      vecs[0] = '{8'h35, 2'b01, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{8'h35, 2'b01, 1'b1, 8'd7, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'h5A, 2'b10, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'hC3, 2'b11, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1};

      do_reset();
      check("reset_outputs", {cur_int, cur_bool, flips, done, solved, tout, bus.search_state}, 32'h0);

      for (int v = 0; v < 4; v++) begin
         do_reset();
         sat       = vecs[v].sat;
         max_flips = vecs[v].mf;
         do_start(vecs[v].ii, vecs[v].ib);
         seq_req = (bus.search_state != 8'd0);
         @(negedge clk);
         seq_req = seq_req | (bus.search_state != 8'd0);
         check($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
         check($sformatf("vec%0d_solved", v), solved, vecs[v].exp_solved);
         check($sformatf("vec%0d_request", v), seq_req, vecs[v].exp_req);
         check($sformatf("vec%0d_assign", v), {cur_bool, cur_int}, {vecs[v].ib, vecs[v].ii});
         check($sformatf("vec%0d_flips_timeout", v), {flips, tout}, 9'h0);
      end

      // Restart from DONE with a new assignment and an empty budget.
      do_reset();
      sat = 1'b1;
      do_start(8'h35, 2'b01);
      @(negedge clk);
      check("restart_first_done", {done, solved}, 2'b11);
      sat = 1'b0;
      max_flips = 8'd0;
      do_start(8'h7E, 2'b10);
      check("restart_leaves_done", {done, solved}, 2'b00);
      @(negedge clk);
      check("restart_done_unsolved", {done, solved}, 2'b10);
      check("restart_assign", {cur_bool, cur_int}, {2'b10, 8'h7E});

      // Always-greedy single step with budget 1.
      do_reset();
      sat = 1'b0; max_flips = 8'd1; thr = 9'd256;
      bus.bestgain = 3'd2;
      bus.best_assignment_integer = 8'hA0;
      bus.best_assignment_boolean = 2'b10;
      do_start(8'h35, 2'b01);
      do_step(1'b1, l);
      check("greedy_assign", {cur_bool, cur_int}, {2'b10, 8'hA0});
      check("greedy_flips", flips, 8'd1);
      @(negedge clk);
      check("greedy_done_unsolved", {done, solved, tout}, 3'b100);
      check("greedy_state_idle", bus.search_state, 8'd0);

      // Random walk: threshold 0, then always-greedy threshold with zero gain.
      do_reset();
      sat = 1'b0; max_flips = 8'd255;
      bus.best_assignment_integer = 8'hEE;
      bus.best_assignment_boolean = 2'b11;
      bus.new_assignments_integer = 32'h33221100;
      bus.new_assignments_boolean = 8'hE4;
      for (int k = 0; k < 4; k++) seen[k] = 1'b0;
      do_start(8'h35, 2'b01);
      for (int s = 0; s < 200; s++) begin
         if (s < 100) begin thr = 9'd0;   bus.bestgain = 3'd5; end
         else         begin thr = 9'd256; bus.bestgain = 3'd0; end
         do_step(1'b0, l);
         idx = (int'(l) / 8192) % 4;
         check($sformatf("walk%0d", s), {cur_bool, cur_int}, {idx[1:0], 8'(idx * 17)});
         for (int k = 0; k < 4; k++) if (cur_int == 8'(k * 17)) seen[k] = 1'b1;
      end
      n_seen = 0;
      for (int k = 0; k < 4; k++) n_seen += int'(seen[k]);
      check("walk_all_indices", n_seen, 4);
      check("walk_flips", flips, 8'd200);

      // Randomized threshold, gain and candidates against the reference model.
      do_reset();
      sat = 1'b0; max_flips = 8'd40;
      do_start(8'($urandom), 2'($urandom));
      for (int s = 0; s < 40; s++) begin
         th = 9'($urandom_range(0, 256));
         g  = 3'($urandom_range(0, 7));
         bi = 8'($urandom); bb = 2'($urandom);
         ni = $urandom;     nb = 8'($urandom);
         thr = th;
         bus.bestgain = g;
         bus.best_assignment_integer = bi;
         bus.best_assignment_boolean = bb;
         bus.new_assignments_integer = ni;
         bus.new_assignments_boolean = nb;
         do_step(1'b1, l);
         idx    = (int'(l) / 8192) % 4;
         greedy = (int'(l) % 256 < int'(th)) && (g != 3'd0);
         e_int  = greedy ? bi : 8'(ni >> (idx * 8));
         e_bool = greedy ? bb : 2'(nb >> (idx * 2));
         check($sformatf("rand%0d_greedy%0d", s, greedy), {cur_bool, cur_int}, {e_bool, e_int});
      end
      @(negedge clk);
      check("rand_budget_done", {done, solved, tout}, 3'b100);
      check("rand_flips", flips, 8'd40);

      // Watchdog expiry with no ready pulse.
      do_reset();
      sat = 1'b0; max_flips = 8'd5;
      do_start(8'h96, 2'b10);
      wait_request(ok);
      @(negedge clk);
      check("wait_state_code", bus.search_state, 8'h02);
      repeat (63) @(negedge clk);
      check("timeout_not_yet", {done, tout}, 2'b00);
      @(negedge clk);
      check("timeout_flag", {done, solved, tout}, 3'b101);
      check("timeout_state_idle", bus.search_state, 8'd0);
      check("timeout_assign_kept", {cur_bool, cur_int, flips}, {2'b10, 8'h96, 8'd0});

      // Ready on the expiry cycle wins.
      do_reset();
      sat = 1'b0; max_flips = 8'd5; thr = 9'd256;
      bus.bestgain = 3'd1;
      bus.best_assignment_integer = 8'h5C;
      bus.best_assignment_boolean = 2'b01;
      do_start(8'h96, 2'b10);
      wait_request(ok);
      @(negedge clk);
      repeat (63) @(negedge clk);
      bus.search_ready = 1'b1;
      @(negedge clk);
      bus.search_ready = 1'b0;
      check("race_in_commit", {done, tout}, 2'b00);
      @(negedge clk);
      check("race_assign", {cur_bool, cur_int}, {2'b01, 8'h5C});
      check("race_flips_timeout", {flips, tout}, {8'd1, 1'b0});

      // Asynchronous reset in WAIT, then a clean restart on a reseeded LFSR.
      wait_request(ok);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_reset_outputs", {cur_int, cur_bool, flips, done, solved, tout, bus.search_state}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      thr = 9'd0;
      bus.bestgain = 3'd1;
      bus.new_assignments_integer = 32'h33221100;
      bus.new_assignments_boolean = 8'hE4;
      sat = 1'b0; max_flips = 8'd3;
      do_start(8'h12, 2'b00);
      for (int s = 0; s < 3; s++) begin
         do_step(1'b0, l);
         idx = (int'(l) / 8192) % 4;
         check($sformatf("reseed%0d", s), {cur_bool, cur_int}, {idx[1:0], 8'(idx * 17)});
      end
      @(negedge clk);
      check("reseed_done", {done, flips}, {1'b1, 8'd3});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
